// File: rtl/bg_pkg.sv
// Shared definitions for the background effect sequencer: mode encodings,
// effect bit positions and the per-mode enable_effect patterns.
package bg_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE    = 2'd0,
        MODE_ATTRACT = 2'd1,
        MODE_INTRO   = 2'd2,
        MODE_FLASH   = 2'd3
    } mode_e;

    localparam int EFF_WAVE  = 0;
    localparam int EFF_IMAGE = 1;
    localparam int EFF_BANK  = 2;

    localparam logic [2:0] EFF_BIT_WAVE  = 3'(1 << EFF_WAVE);
    localparam logic [2:0] EFF_BIT_IMAGE = 3'(1 << EFF_IMAGE);
    localparam logic [2:0] EFF_BIT_BANK  = 3'(1 << EFF_BANK);

    localparam logic [2:0] EFF_OFF      = 3'b000;
    localparam logic [2:0] EFF_ATTRACT  = EFF_BIT_WAVE | EFF_BIT_IMAGE;
    localparam logic [2:0] EFF_INTRO    = EFF_BIT_WAVE;
    localparam logic [2:0] EFF_FLASH_B1 = EFF_BIT_IMAGE | EFF_BIT_BANK;
    localparam logic [2:0] EFF_FLASH_B0 = EFF_BIT_IMAGE;

    // FLASH alternates image banks: phase 0 shows bank 1, phase 1 shows bank 0.
    function automatic logic [2:0] effect_for(input mode_e mode, input logic phase);
        case (mode)
            MODE_ATTRACT: effect_for = EFF_ATTRACT;
            MODE_INTRO:   effect_for = EFF_INTRO;
            MODE_FLASH:   effect_for = phase ? EFF_FLASH_B0 : EFF_FLASH_B1;
            default:      effect_for = EFF_OFF;
        endcase
    endfunction

    function automatic logic is_timed(input mode_e mode);
        is_timed = (mode == MODE_INTRO) || (mode == MODE_FLASH);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a registered one-cycle scroll_tick every
// TICK_DIV clock cycles; the first pulse appears TICK_DIV cycles after reset.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 1562500
) (
    input  logic clk,
    input  logic rst,
    output logic o_scroll_tick
);

    localparam logic [23:0] LAST_COUNT = 24'(TICK_DIV - 1);

    logic [23:0] r_count;
    logic        r_tick;
    logic        w_wrap;

    assign w_wrap = (r_count == LAST_COUNT);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of r_count; blocking here would race the compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 24'd0;
            r_tick  <= 1'b0;
        end else begin
            r_count <= w_wrap ? 24'd0 : r_count + 24'd1;
            r_tick  <= w_wrap;
        end
    end

    assign o_scroll_tick = r_tick;

endmodule

// File: rtl/bg_effect_sequencer.sv
// Frame-synchronous mode sequencer for the background effects renderer:
// latches mode requests and applies them at frame_start, times INTRO/FLASH.
module bg_effect_sequencer
    import bg_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 1562500,
    parameter int unsigned INTRO_TICKS = 40,
    parameter int unsigned FLASH_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_frame_start,
    input  logic       i_req_valid,
    input  logic [1:0] i_req_mode,
    output logic       o_req_ready,
    output logic [2:0] o_enable_effect,
    output logic       o_scroll_tick,
    output logic       o_busy,
    output logic       o_done
);

    mode_e       r_state;
    mode_e       r_pend_mode;
    logic        r_pending;
    logic        r_tick_seen;
    logic [7:0]  r_cnt;
    logic        r_phase;
    logic [2:0]  r_enable_effect;
    logic        r_busy;
    logic        r_done;

    logic        w_tick;
    logic        w_accept;
    logic        w_tick_avail;
    logic [7:0]  w_limit;
    logic        w_last;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk           (clk),
        .rst           (rst),
        .o_scroll_tick (w_tick)
    );

    assign o_req_ready  = !r_pending;
    assign w_accept     = i_req_valid && !r_pending;
    // A tick arriving on the frame_start cycle itself still counts for this frame.
    assign w_tick_avail = r_tick_seen || w_tick;
    assign w_limit      = (r_state == MODE_FLASH) ? 8'(FLASH_TICKS) : 8'(INTRO_TICKS);
    assign w_last       = (r_cnt == w_limit - 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= MODE_IDLE;
            r_pend_mode     <= MODE_IDLE;
            r_pending       <= 1'b0;
            r_tick_seen     <= 1'b0;
            r_cnt           <= 8'd0;
            r_phase         <= 1'b0;
            r_enable_effect <= EFF_OFF;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_pending   <= 1'b1;
                r_pend_mode <= mode_e'(i_req_mode);
            end

            if (i_frame_start) begin
                r_tick_seen <= 1'b0;
            end else if (w_tick) begin
                r_tick_seen <= 1'b1;
            end

            // Accept needs !r_pending and apply needs r_pending, so they never collide.
            if (i_frame_start) begin
                if (r_pending) begin
                    r_pending       <= 1'b0;
                    r_state         <= r_pend_mode;
                    r_cnt           <= 8'd0;
                    r_phase         <= 1'b0;
                    r_enable_effect <= effect_for(r_pend_mode, 1'b0);
                    r_busy          <= is_timed(r_pend_mode);
                end else if (is_timed(r_state) && w_tick_avail) begin
                    if (w_last) begin
                        r_state         <= MODE_IDLE;
                        r_cnt           <= 8'd0;
                        r_phase         <= 1'b0;
                        r_enable_effect <= EFF_OFF;
                        r_busy          <= 1'b0;
                        r_done          <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_state == MODE_FLASH) begin
                            r_phase         <= !r_phase;
                            r_enable_effect <= effect_for(MODE_FLASH, !r_phase);
                        end
                    end
                end
            end
        end
    end

    assign o_enable_effect = r_enable_effect;
    assign o_scroll_tick   = w_tick;
    assign o_busy          = r_busy;
    assign o_done          = r_done;

endmodule

// File: tb/tb_bg_effect_sequencer.sv
// Directed, table-driven bench for bg_effect_sequencer with TICK_DIV=4,
// INTRO_TICKS=3, FLASH_TICKS=2 and frame_start every 10 cycles.
module tb_bg_effect_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_frame_start;
    logic       i_req_valid;
    logic [1:0] i_req_mode;
    logic       o_req_ready;
    logic [2:0] o_enable_effect;
    logic       o_scroll_tick;
    logic       o_busy;
    logic       o_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bg_effect_sequencer #(
        .TICK_DIV    (4),
        .INTRO_TICKS (3),
        .FLASH_TICKS (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_frame_start   (i_frame_start),
        .i_req_valid     (i_req_valid),
        .i_req_mode      (i_req_mode),
        .o_req_ready     (o_req_ready),
        .o_enable_effect (o_enable_effect),
        .o_scroll_tick   (o_scroll_tick),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    typedef struct {
        int         step;
        logic       valid;
        logic [1:0] mode;
        logic [2:0] en;
        logic       busy;
        logic       done;
        logic       ready;
        logic       tick;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int step, input logic valid, input logic [1:0] mode,
                       input logic [2:0] en, input logic busy, input logic done,
                       input logic ready, input logic tick);
        vec_t v;
        v.step = step; v.valid = valid; v.mode = mode; v.en = en;
        v.busy = busy; v.done = done; v.ready = ready; v.tick = tick;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] en, input logic busy,
                                 input logic done, input logic ready, input logic tick);
        check({tag, " enable_effect"}, 8'(o_enable_effect), 8'(en));
        check({tag, " busy"},          8'(o_busy),          8'(busy));
        check({tag, " done"},          8'(o_done),          8'(done));
        check({tag, " req_ready"},     8'(o_req_ready),     8'(ready));
        check({tag, " scroll_tick"},   8'(o_scroll_tick),   8'(tick));
    endtask

    // Drive one cycle of inputs, let the edge sample them, look at outputs 1 time unit later.
    task automatic step(input logic fs, input logic valid, input logic [1:0] mode);
        i_frame_start = fs;
        i_req_valid   = valid;
        i_req_mode    = mode;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;

        // step, valid, mode, en, busy, done, ready, tick (step = edges since reset release)
        add(  1, 0, 2'd0, 3'b000, 0, 0, 1, 0);
        add(  3, 0, 2'd0, 3'b000, 0, 0, 1, 0);
        add(  4, 0, 2'd0, 3'b000, 0, 0, 1, 1);
        add(  5, 0, 2'd0, 3'b000, 0, 0, 1, 0);
        add(  8, 0, 2'd0, 3'b000, 0, 0, 1, 1);
        add( 12, 0, 2'd0, 3'b000, 0, 0, 1, 1);
        add( 13, 1, 2'd1, 3'b000, 0, 0, 0, 0);
        add( 14, 0, 2'd0, 3'b000, 0, 0, 0, 0);
        add( 19, 0, 2'd0, 3'b000, 0, 0, 0, 0);
        add( 20, 0, 2'd0, 3'b011, 0, 0, 1, 1);
        add( 22, 1, 2'd2, 3'b011, 0, 0, 0, 0);
        add( 29, 0, 2'd0, 3'b011, 0, 0, 0, 0);
        add( 30, 0, 2'd0, 3'b001, 1, 0, 1, 0);
        add( 40, 0, 2'd0, 3'b001, 1, 0, 1, 1);
        add( 50, 0, 2'd0, 3'b001, 1, 0, 1, 0);
        add( 59, 0, 2'd0, 3'b001, 1, 0, 1, 0);
        add( 60, 0, 2'd0, 3'b000, 0, 1, 1, 1);
        add( 61, 0, 2'd0, 3'b000, 0, 0, 1, 0);
        add( 62, 1, 2'd3, 3'b000, 0, 0, 0, 0);
        add( 70, 0, 2'd0, 3'b110, 1, 0, 1, 0);
        add( 79, 0, 2'd0, 3'b110, 1, 0, 1, 0);
        add( 80, 0, 2'd0, 3'b010, 1, 0, 1, 1);
        add( 89, 0, 2'd0, 3'b010, 1, 0, 1, 0);
        add( 90, 0, 2'd0, 3'b000, 0, 1, 1, 0);
        add( 91, 0, 2'd0, 3'b000, 0, 0, 1, 0);
        add( 92, 1, 2'd2, 3'b000, 0, 0, 0, 1);
        add(100, 0, 2'd0, 3'b001, 1, 0, 1, 1);
        add(110, 0, 2'd0, 3'b001, 1, 0, 1, 0);
        add(120, 0, 2'd0, 3'b001, 1, 0, 1, 1);
        add(122, 1, 2'd1, 3'b001, 1, 0, 0, 0);
        add(130, 0, 2'd0, 3'b011, 0, 0, 1, 0);
        add(131, 0, 2'd0, 3'b011, 0, 0, 1, 0);
        add(132, 1, 2'd0, 3'b011, 0, 0, 0, 1);
        add(135, 1, 2'd3, 3'b011, 0, 0, 0, 0);
        add(139, 0, 2'd0, 3'b011, 0, 0, 0, 0);
        add(140, 0, 2'd0, 3'b000, 0, 0, 1, 1);
        add(150, 0, 2'd0, 3'b000, 0, 0, 1, 0);
        add(160, 1, 2'd3, 3'b000, 0, 0, 0, 1);
        add(169, 0, 2'd0, 3'b000, 0, 0, 0, 0);
        add(170, 0, 2'd0, 3'b110, 1, 0, 1, 0);
        add(172, 1, 2'd1, 3'b110, 1, 0, 0, 1);

        rst = 1'b1;
        i_frame_start = 1'b0;
        i_req_valid   = 1'b0;
        i_req_mode    = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("in_reset", 3'b000, 0, 0, 1, 0);
        rst = 1'b0;

        idx = 0;
        for (int s = 1; s <= 174; s++) begin
            if (idx < tbl.size() && tbl[idx].step == s) begin
                step((s % 10) == 0, tbl[idx].valid, tbl[idx].mode);
                check_outputs($sformatf("s%0d", s), tbl[idx].en, tbl[idx].busy,
                              tbl[idx].done, tbl[idx].ready, tbl[idx].tick);
                idx++;
            end else begin
                step((s % 10) == 0, 1'b0, 2'd0);
            end
        end

        // Mid-FLASH with an ATTRACT request pending: reset must clear everything at once.
        #1;
        rst = 1'b1;
        #1;
        check_outputs("async_rst", 3'b000, 0, 0, 1, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Prescaler restarts from 0; the discarded ATTRACT must not appear at the next frame.
        for (int k = 1; k <= 12; k++) begin
            step((k % 10) == 0, 1'b0, 2'd0);
            if (k == 3 || k == 4 || k == 5 || k == 10 || k == 12)
                check_outputs($sformatf("post_rst_k%0d", k), 3'b000, 0, 0, 1, (k % 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
